fp_add_pipe: RTL

Parametrised, pipelined floating-point adder/subtractor for the matmul datapath. Defaults to bfloat16, and any IEEE-style {sign, exponent, fraction} format can be selected by parameter. It adds the behaviour the combinational bf16 adder lacks: a 3-stage registered pipeline with valid/ready flow control, per-operation add/subtract select, round-to-nearest-even, a pass-through tag, and correct IEEE special-value handling. It sits between the PE multiplier outputs and the accumulator writeback.

---
 rtl/fp_add_pipe_if.sv | 29 ++
 rtl/fp_add_pipe.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fp_add_pipe_if.sv
// rtl/fp_add_pipe_if.sv - operand/result handshake bundle for fp_add_pipe
interface fp_add_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    parameter int TAG_W = 4
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             in_sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

    modport master (
        output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/fp_add_pipe.sv
// rtl/fp_add_pipe.sv - 3-stage pipelined FP add/sub, RNE rounding, FTZ, IEEE specials
// Stages: unpack/align -> add/sub -> normalise/round/pack; one global advance enable.
module fp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    parameter int TAG_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    fp_add_pipe_if.slave io
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 5;
    localparam int NW  = MAN_W + 4;
    localparam int AW  = 2 * MAN_W + 6;
    localparam int SAT = MAN_W + 3;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    logic en, in_ready;

    logic             s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d, s1_sub_q, s1_sub_d;
    logic             s1_force_q, s1_force_d;
    logic [W-1:0]     s1_fval_q, s1_fval_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
    logic [NW-1:0]    s1_ml_q, s1_ml_d, s1_ms_q, s1_ms_d;

    logic             s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d, s2_force_q, s2_force_d;
    logic [W-1:0]     s2_fval_q, s2_fval_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
    logic [SW-1:0]    s2_sum_q, s2_sum_d;

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    assign en          = !out_valid_q || io.out_ready;
    assign in_ready    = en && !rst;
    assign io.in_ready = in_ready;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_tag   = out_tag_q;

    logic             a_s, b_s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big, s_zero;
    logic [EXP_W-1:0] a_e, b_e, l_e, s_e;
    logic [MAN_W-1:0] a_mf, b_mf, l_mf, s_mf;
    logic [MAN_W:0]   s_sig;
    logic [AW-1:0]    wide, shifted;
    int               diff, sh;

    always_comb begin : stage1
        a_s    = io.in_a[W-1];
        b_s    = io.in_b[W-1] ^ io.in_sub;
        a_e    = io.in_a[W-2 -: EXP_W];
        b_e    = io.in_b[W-2 -: EXP_W];
        a_zero = (a_e == '0);
        b_zero = (b_e == '0);
        a_inf  = (a_e == EXP_ONES) && (io.in_a[MAN_W-1:0] == '0);
        b_inf  = (b_e == EXP_ONES) && (io.in_b[MAN_W-1:0] == '0);
        a_nan  = (a_e == EXP_ONES) && (io.in_a[MAN_W-1:0] != '0);
        b_nan  = (b_e == EXP_ONES) && (io.in_b[MAN_W-1:0] != '0);
        // Subnormals are flushed: their fraction never reaches the datapath.
        a_mf   = a_zero ? '0 : io.in_a[MAN_W-1:0];
        b_mf   = b_zero ? '0 : io.in_b[MAN_W-1:0];
        a_big  = {a_e, a_mf} >= {b_e, b_mf};
        l_e    = a_big ? a_e : b_e;
        s_e    = a_big ? b_e : a_e;
        l_mf   = a_big ? a_mf : b_mf;
        s_mf   = a_big ? b_mf : a_mf;
        s_zero = a_big ? b_zero : a_zero;
        diff   = int'(l_e) - int'(s_e);
        sh     = (diff > SAT) ? SAT : diff;
        s_sig  = s_zero ? '0 : {1'b1, s_mf};
        wide   = {s_sig, {(MAN_W + 5){1'b0}}};
        shifted = wide >> sh;

        s1_valid_d = io.in_valid && in_ready;
        s1_tag_d   = io.in_tag;
        s1_sign_d  = a_big ? a_s : b_s;
        s1_sub_d   = a_s ^ b_s;
        s1_exp_d   = l_e;
        s1_ml_d    = {1'b1, l_mf, 3'b000};
        s1_ms_d    = {shifted[AW-1 -: MAN_W + 3], |shifted[MAN_W+2:0]};
        s1_force_d = 1'b1;
        s1_fval_d  = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) begin
            s1_fval_d = {1'b0, EXP_ONES, 1'b1, {(MAN_W - 1){1'b0}}};
        end else if (a_inf) begin
            s1_fval_d = {a_s, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            s1_fval_d = {b_s, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            s1_fval_d = {a_s & b_s, {(W - 1){1'b0}}};
        end else begin
            s1_force_d = 1'b0;
        end
    end

    always_comb begin : stage2
        s2_valid_d = s1_valid_q;
        s2_tag_d   = s1_tag_q;
        s2_sign_d  = s1_sign_q;
        s2_exp_d   = s1_exp_q;
        s2_force_d = s1_force_q;
        s2_fval_d  = s1_fval_q;
        // Larger magnitude is always the minuend, so the difference is never negative.
        s2_sum_d   = s1_sub_q ? ({1'b0, s1_ml_q} - {1'b0, s1_ms_q})
                              : ({1'b0, s1_ml_q} + {1'b0, s1_ms_q});
    end

    logic           carry, round_up;
    logic [NW-1:0]  norm;
    logic [MAN_W+1:0] rmant;
    logic [MAN_W-1:0] frac;
    int             lzc, e_f;

    always_comb begin : stage3
        carry = s2_sum_q[SW-1];
        lzc   = 0;
        for (int i = 0; i < NW; i++) begin
            if (s2_sum_q[i]) lzc = NW - 1 - i;
        end
        if (carry) begin
            lzc  = 0;
            norm = {s2_sum_q[SW-1:2], s2_sum_q[1] | s2_sum_q[0]};
        end else begin
            norm = s2_sum_q[NW-1:0] << lzc;
        end
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rmant    = {1'b0, norm[NW-1:3]} + {{(MAN_W + 1){1'b0}}, round_up};
        frac     = rmant[MAN_W+1] ? '0 : rmant[MAN_W-1:0];
        e_f      = int'(s2_exp_q) + (carry ? 1 : 0) - lzc + (rmant[MAN_W+1] ? 1 : 0);

        out_valid_d = s2_valid_q;
        out_tag_d   = s2_tag_q;
        if (s2_force_q) begin
            out_data_d = s2_fval_q;
        end else if (s2_sum_q == '0) begin
            out_data_d = '0;
        end else if (e_f <= 0) begin
            out_data_d = {s2_sign_q, {(W - 1){1'b0}}};
        end else if (e_f >= int'(EXP_ONES)) begin
            out_data_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
        end else begin
            out_data_d = {s2_sign_q, e_f[EXP_W-1:0], frac};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else if (en) begin
            s1_valid_q  <= s1_valid_d;
            s1_tag_q    <= s1_tag_d;
            s1_sign_q   <= s1_sign_d;
            s1_sub_q    <= s1_sub_d;
            s1_exp_q    <= s1_exp_d;
            s1_ml_q     <= s1_ml_d;
            s1_ms_q     <= s1_ms_d;
            s1_force_q  <= s1_force_d;
            s1_fval_q   <= s1_fval_d;
            s2_valid_q  <= s2_valid_d;
            s2_tag_q    <= s2_tag_d;
            s2_sign_q   <= s2_sign_d;
            s2_exp_q    <= s2_exp_d;
            s2_sum_q    <= s2_sum_d;
            s2_force_q  <= s2_force_d;
            s2_fval_q   <= s2_fval_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
        end
    end
endmodule
